addsub_seq: RTL
===============

ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter NBYTE_MAX, default 4, giving the maximum operand width in bytes; only 4 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 The block SHALL have port nbytes, input, 2 bits: operand length minus one (0 = 1 byte ... 3 = 4 bytes); sampled with start.
REQ-007 The block SHALL have ports a and b, inputs, 32 bits each: operands, byte 0 = bits 7:0; sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 32 bits: sum or difference.
REQ-011 The block SHALL have port carry_out, output, 1 bit: carry from the most significant processed byte.
REQ-012 The block SHALL have port overflow, output, 1 bit: signed overflow of the N-byte operation.

Function
REQ-013 The block SHALL contain exactly one 8-bit ripple-carry adder (8 full-adder bit slices) and SHALL compute every byte of the result through it, one byte per cycle.
REQ-014 The block SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start=1; RUN->DONE after the last byte; DONE->IDLE unconditionally after one cycle.
REQ-015 On accepting start, the block SHALL latch a, b, op and nbytes, clear result, and set the byte index to 0; later input changes SHALL have no effect until the operation ends.
REQ-016 Adder inputs SHALL be a-byte[i] and b-byte[i] for add, or a-byte[i] and ~b-byte[i] for subtract; carry-in SHALL be op for byte 0 and the registered carry of byte i-1 for later bytes.
REQ-017 At each RUN edge, the block SHALL write adder sum into result byte i, register the carry, and increment i; when i equals nbytes, the next state SHALL be DONE.
REQ-018 Latency SHALL be fixed: with start sampled at edge k, done SHALL be high for exactly the cycle following edge k+nbytes+1; total busy time is nbytes+2 cycles.
REQ-019 Result bytes above nbytes SHALL read 0.
REQ-020 carry_out SHALL be the carry of byte nbytes; for subtract, 1 means no borrow.
REQ-021 overflow SHALL be the carry into bit 7 XOR the carry out of bit 7 of byte nbytes.
REQ-022 result, carry_out and overflow SHALL be updated when done rises and SHALL hold until the next accepted start.
REQ-023 start while busy=1, including the DONE cycle, SHALL be ignored without queuing; start held high in IDLE SHALL launch a new operation at that edge.

Reset
REQ-024 rst_n=0 SHALL force, immediately and asynchronously, state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, and byte index 0, including in the middle of RUN.
REQ-025 After rst_n deasserts, the first rising clock edge with start=1 SHALL be accepted normally.

Verification
REQ-026 The bench SHALL apply add, nbytes=3, a=0x000000FF, b=0x00000001 and check result=0x00000100, carry_out=0, overflow=0, with done exactly 5 cycles after the start edge.
REQ-027 The bench SHALL apply sub, nbytes=0, a=0x05, b=0x07 and check result=0x000000FE, carry_out=0, overflow=0, with done 2 cycles after start.
REQ-028 The bench SHALL apply add, nbytes=1, a=0x7FFF, b=0x0001 and check result=0x00008000, overflow=1, carry_out=0.
REQ-029 The bench SHALL apply add, nbytes=3, a=0xFFFFFFFF, b=0x00000001 and check result=0x00000000, carry_out=1, overflow=0.
REQ-030 The bench SHALL pulse start with new operands in RUN and in DONE and check that the pulse is ignored and the first result is unchanged.
REQ-031 The bench SHALL assert rst_n=0 during RUN byte 2 and check that all outputs go to 0 without a clock edge; it SHALL then run a new add to completion and check the result is correct.

Source files
------------

// File: rtl/addsub_seq.sv
// Byte-serial adder/subtractor: one 8-bit ripple-carry adder processes one
// operand byte per cycle, least significant byte first.
module addsub_seq #(
    parameter int NBYTE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [1:0]             nbytes,
    input  logic [8*NBYTE_MAX-1:0] a,
    input  logic [8*NBYTE_MAX-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [8*NBYTE_MAX-1:0] result,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int W = 8 * NBYTE_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_op;
    logic [1:0]     r_nbytes;
    logic [1:0]     r_idx;
    logic           r_carry;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_result;
    logic           r_cout;
    logic           r_ovf;

    logic [7:0]     w_x;
    logic [7:0]     w_y;
    logic [7:0]     w_sum;
    logic [8:0]     w_c;
    logic           w_last;
    logic [W-1:0]   w_acc_next;

    // Operand byte selection; subtract is a + ~b + 1 with the +1 as carry-in of byte 0.
    always_comb begin
        w_x    = r_a[{r_idx, 3'b000} +: 8];
        w_y    = r_op ? ~r_b[{r_idx, 3'b000} +: 8] : r_b[{r_idx, 3'b000} +: 8];
        w_c[0] = (r_idx == 2'd0) ? r_op : r_carry;
        w_last = (r_idx == r_nbytes);
    end

    for (genvar g = 0; g < 8; g++) begin : g_fa
        assign w_sum[g]  = w_x[g] ^ w_y[g] ^ w_c[g];
        assign w_c[g+1]  = (w_x[g] & w_y[g]) | (w_c[g] & (w_x[g] ^ w_y[g]));
    end

    always_comb begin
        w_acc_next                        = r_acc;
        w_acc_next[{r_idx, 3'b000} +: 8]  = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Partial sums build up in r_acc; visible outputs change only at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_nbytes <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_op     <= op;
                    r_nbytes <= nbytes;
                    r_idx    <= '0;
                    r_carry  <= 1'b0;
                    r_acc    <= '0;
                    r_result <= '0;
                    r_cout   <= 1'b0;
                    r_ovf    <= 1'b0;
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_c[8];
                    r_idx   <= r_idx + 2'd1;
                    if (w_last) begin
                        r_result <= w_acc_next;
                        r_cout   <= w_c[8];
                        r_ovf    <= w_c[7] ^ w_c[8];
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule
